header_stream_arbiter: RTL and testbench
========================================

Name: header_stream_arbiter

Overview:
Packet-granular round-robin arbiter that shares one header-insertion datapath among NUM_PORTS AXI-stream sources.
Each source supplies its own header word. The arbiter grants one whole packet at a time, muxes that source's beats onto the master stream, and holds the granted source's latched header stable for the full packet.
Sits directly upstream of header_insertion: m_* drives its tvalid_in/tdata_in/tlast_in/tkeep_in, and m_header drives header_data.

Parameters:
NUM_PORTS, 4, number of requesting streams (>=2)
BITS_PER_BEAT, 512, tdata width
HEADER_SIZE, 112, per-port header width
PORT_W, $clog2(NUM_PORTS), derived localparam; grant index width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
s_tvalid  in  NUM_PORTS  per-port valid
s_tdata  in  NUM_PORTS*BITS_PER_BEAT  port p occupies slice [p*BITS_PER_BEAT +: BITS_PER_BEAT]
s_tlast  in  NUM_PORTS  per-port last
s_tkeep  in  NUM_PORTS*BITS_PER_BEAT/8  per-port keep
s_tready  out  NUM_PORTS  per-port ready
s_header  in  NUM_PORTS*HEADER_SIZE  per-port header
port_enable  in  NUM_PORTS  per-port arbitration mask
m_tvalid  out  1  to header_insertion
m_tdata  out  BITS_PER_BEAT
m_tlast  out  1
m_tkeep  out  BITS_PER_BEAT/8
m_tready  in  1  from header_insertion
m_header  out  HEADER_SIZE  latched header of the granted port
active_port  out  PORT_W  current or last grant index
busy  out  1  high while a packet is granted
packet_count  out  32  completed packets, wraps 2^32-1 -> 0

Behaviour:
- Reset (reset==0, asynchronous): state IDLE; rr_ptr=0; active_port=0; m_header=0; busy=0; packet_count=0.
- While in reset, and in IDLE: m_tvalid=0 and s_tready=0.
- State IDLE:
  - req = s_tvalid & port_enable.
  - If req!=0: pick the first set bit of req starting at rr_ptr and wrapping modulo NUM_PORTS.
  - Register that index into active_port and s_header[winner] into m_header; set busy=1; go to GRANT.
  - If req==0: stay in IDLE.
- State GRANT (combinational mux on active_port g):
  - m_tvalid=s_tvalid[g]; m_tdata/m_tlast/m_tkeep = slice g.
  - s_tready[g]=m_tready; all other s_tready bits=0.
- A beat transfers when m_tvalid & m_tready. On a transfer with m_tlast=1:
  - go to IDLE; rr_ptr=(g+1) mod NUM_PORTS; packet_count+=1; busy=0.
  - m_header and active_port hold their last value.
- Latency and throughput: the grant takes effect one cycle after req is seen in IDLE. One bubble cycle follows every packet (IDLE re-arbitrates), so at most one packet per (beats+1) cycles.
- m_header is constant from the grant until the cycle after the tlast handshake. s_header changes during GRANT are ignored.
- port_enable[g] deasserting mid-packet has no effect until tlast. The mask only gates new grants.
- s_tvalid[g] dropping mid-packet: m_tvalid drops and the grant is held. There is no timeout.
- Single-beat packet (tlast on first beat) is legal: one GRANT cycle, then IDLE.
- rr_ptr wraps from NUM_PORTS-1 to 0.
- m_tready low: the beat is stalled and s_tready[g] is low; no state change.
- Reset asserted mid-packet: immediate return to IDLE, outputs at reset values. The partial packet is the source's responsibility.

Decomposition:
- Shared package holds:
  - state encodings IDLE/GRANT;
  - PORT_W derivation;
  - packet counter width constant (32);
  - the header/beat slicing helper macros.
- One sub-module: rr_priority_picker (combinational; inputs req[NUM_PORTS], ptr[PORT_W]; outputs grant_idx[PORT_W], grant_valid).

Test Plan:
- Port 2 only, 3-beat packet, header 112'hA5.., m_tready=1 -> grant 1 cycle after valid; 3 beats on m_*; m_header=112'hA5.. throughout; packet_count=1; rr_ptr=3.
- All 4 ports valid continuously, 2-beat packets -> grant order 0,1,2,3,0; one idle cycle between packets; packet_count=5.
- Port 1 granted, m_tready toggles 1,0,0,1 mid-packet -> no beat lost or duplicated; s_tready[1] follows m_tready; s_tready[0,2,3]=0 throughout.
- port_enable=4'b1011 with all valid -> port 2 never granted; port_enable[1] cleared mid-packet -> port 1 packet completes, then is skipped.
- reset pulsed low during beat 2 of a 4-beat packet -> m_tvalid=0 and s_tready=0 immediately; after release packet_count=0; first grant goes to port 0.
- packet_count preloaded to 32'hFFFFFFFF via 2^32 packets (forced) or a backdoor, then one packet -> packet_count=0.

Source files
------------

// File: rtl/header_stream_arbiter_pkg.sv
// Shared types and helpers for the header stream arbiter: FSM encoding,
// grant-index width derivation, counter width and bus slicing.
`ifndef HEADER_STREAM_ARBITER_PKG_SV
`define HEADER_STREAM_ARBITER_PKG_SV

// Selects element idx of width w from a flat concatenated bus.
`define HSA_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package header_stream_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int PKT_CNT_W = 32;

  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/header_stream_arbiter_if.sv
// Per-port source streams plus the single muxed master stream and its header.
interface header_stream_arbiter_if #(
  parameter int NUM_PORTS     = 4,
  parameter int BITS_PER_BEAT = 512,
  parameter int HEADER_SIZE   = 112
);
  localparam int KEEP_W = BITS_PER_BEAT / 8;

  logic [NUM_PORTS-1:0]               s_tvalid;
  logic [NUM_PORTS*BITS_PER_BEAT-1:0] s_tdata;
  logic [NUM_PORTS-1:0]               s_tlast;
  logic [NUM_PORTS*KEEP_W-1:0]        s_tkeep;
  logic [NUM_PORTS-1:0]               s_tready;
  logic [NUM_PORTS*HEADER_SIZE-1:0]   s_header;

  logic                     m_tvalid;
  logic [BITS_PER_BEAT-1:0] m_tdata;
  logic                     m_tlast;
  logic [KEEP_W-1:0]        m_tkeep;
  logic                     m_tready;
  logic [HEADER_SIZE-1:0]   m_header;

  // Arbiter side: consumes the sources, drives the master stream.
  modport master (
    input  s_tvalid, s_tdata, s_tlast, s_tkeep, s_header, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tkeep, m_header
  );

  // Environment side: sources plus the downstream sink.
  modport slave (
    output s_tvalid, s_tdata, s_tlast, s_tkeep, s_header, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tkeep, m_header
  );
endinterface

// File: rtl/header_stream_arbiter_rr_priority_picker.sv
// Round-robin priority pick: first set bit of req at or above ptr, else the
// lowest set bit overall (wrap-around).
module rr_priority_picker
  import header_stream_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = port_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [PORT_W-1:0]    grant_idx,
  output logic                 grant_valid
);
  logic [NUM_PORTS-1:0] hi_req;

  always_comb begin
    hi_req      = '0;
    grant_idx   = '0;
    grant_valid = |req;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hi_req[i] = req[i] && (i >= int'(ptr));
    end
    // Downward scans so the lowest index is the last write and wins.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) grant_idx = PORT_W'(i);
    end
    if (|hi_req) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (hi_req[i]) grant_idx = PORT_W'(i);
      end
    end
  end
endmodule

// File: rtl/header_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one header-insertion datapath;
// the winner's header is latched at grant and held for the whole packet.
module header_stream_arbiter
  import header_stream_arbiter_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int BITS_PER_BEAT = 512,
  parameter int HEADER_SIZE   = 112,
  localparam int PORT_W       = port_w(NUM_PORTS),
  localparam int KEEP_W       = BITS_PER_BEAT / 8
) (
  input  logic                        clock,
  input  logic                        reset,
  header_stream_arbiter_if.master     strm,
  input  logic [NUM_PORTS-1:0]        port_enable,
  output logic [PORT_W-1:0]           active_port,
  output logic                        busy,
  output logic [PKT_CNT_W-1:0]        packet_count
);
  state_e                 state_q, state_d;
  logic [PORT_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]      active_port_q, active_port_d;
  logic [HEADER_SIZE-1:0] m_header_q, m_header_d;
  logic [PKT_CNT_W-1:0]   packet_count_q, packet_count_d;

  logic [NUM_PORTS-1:0]   req;
  logic [PORT_W-1:0]      grant_idx;
  logic                   grant_valid;
  logic                   last_xfer;

  assign req = strm.s_tvalid & port_enable;

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_picker (
    .req         (req),
    .ptr         (rr_ptr_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    active_port_d  = active_port_q;
    m_header_d     = m_header_q;
    packet_count_d = packet_count_q;
    last_xfer      = strm.s_tvalid[active_port_q] && strm.m_tready &&
                     strm.s_tlast[active_port_q];
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d       = GRANT;
          active_port_d = grant_idx;
          m_header_d    = `HSA_SLICE(strm.s_header, grant_idx, HEADER_SIZE);
        end
      end
      GRANT: begin
        // Grant and header are released only by the tlast handshake.
        if (last_xfer) begin
          state_d        = IDLE;
          rr_ptr_d       = (active_port_q == PORT_W'(NUM_PORTS - 1)) ?
                           '0 : active_port_q + PORT_W'(1);
          packet_count_d = packet_count_q + PKT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    strm.m_tvalid = 1'b0;
    strm.m_tdata  = '0;
    strm.m_tlast  = 1'b0;
    strm.m_tkeep  = '0;
    strm.s_tready = '0;
    strm.m_header = m_header_q;
    if (state_q == GRANT) begin
      strm.m_tvalid                = strm.s_tvalid[active_port_q];
      strm.m_tdata                 = `HSA_SLICE(strm.s_tdata, active_port_q, BITS_PER_BEAT);
      strm.m_tlast                 = strm.s_tlast[active_port_q];
      strm.m_tkeep                 = `HSA_SLICE(strm.s_tkeep, active_port_q, KEEP_W);
      strm.s_tready[active_port_q] = strm.m_tready;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      active_port_q  <= '0;
      m_header_q     <= '0;
      packet_count_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      active_port_q  <= active_port_d;
      m_header_q     <= m_header_d;
      packet_count_q <= packet_count_d;
    end
  end

  assign active_port  = active_port_q;
  assign busy         = (state_q == GRANT);
  assign packet_count = packet_count_q;
endmodule

// File: tb/tb_header_stream_arbiter.sv
// Directed bench: per-port packet sources, a cycle-level arbitration model
// and a beat scoreboard, checked on every falling edge.
module tb_header_stream_arbiter;
  localparam int NP = 4;
  localparam int BW = 512;
  localparam int HS = 112;
  localparam int KW = BW / 8;

  typedef struct {
    int                len;
    int                id;
    logic [HS-1:0]     hdr;
  } pkt_t;

  logic clock = 1'b0;
  logic reset;
  logic [NP-1:0] port_enable;
  logic [1:0]    active_port;
  logic          busy;
  logic [31:0]   packet_count;

  header_stream_arbiter_if #(.NUM_PORTS(NP), .BITS_PER_BEAT(BW), .HEADER_SIZE(HS)) bus ();

  header_stream_arbiter #(.NUM_PORTS(NP), .BITS_PER_BEAT(BW), .HEADER_SIZE(HS)) dut (
    .clock        (clock),
    .reset        (reset),
    .strm         (bus),
    .port_enable  (port_enable),
    .active_port  (active_port),
    .busy         (busy),
    .packet_count (packet_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic checkw(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_data(input int p, input int id, input int b);
    return {16{8'(p), 8'(id), 8'(b), 8'hC3}};
  endfunction

  // ---------------- sources ----------------
  pkt_t    pq[NP][$];
  int      bidx[NP];
  logic [NP-1:0] fire;
  logic    mtr_q[$];

  initial begin
    bus.s_tvalid = '0; bus.s_tdata = '0; bus.s_tlast = '0;
    bus.s_tkeep = '0; bus.s_header = '0; bus.m_tready = 1'b1;
    for (int p = 0; p < NP; p++) bidx[p] = 0;
    forever begin
      @(posedge clock); #1;
      for (int p = 0; p < NP; p++) begin
        if (!reset) begin
          pq[p].delete();
          bidx[p] = 0;
        end else if (fire[p] && pq[p].size() > 0) begin
          bidx[p]++;
          if (bidx[p] == pq[p][0].len) begin
            void'(pq[p].pop_front());
            bidx[p] = 0;
          end
        end
        if (pq[p].size() > 0) begin
          bus.s_tvalid[p]            = 1'b1;
          bus.s_tdata[p*BW +: BW]    = mk_data(p, pq[p][0].id, bidx[p]);
          bus.s_tlast[p]             = (bidx[p] == pq[p][0].len - 1);
          bus.s_tkeep[p*KW +: KW]    = (bidx[p] == pq[p][0].len - 1) ? 64'h0000_0000_FFFF_FFFF : '1;
          // Header deliberately wobbles per beat; only the beat-0 value may be latched.
          bus.s_header[p*HS +: HS]   = pq[p][0].hdr ^ HS'(bidx[p]);
        end else begin
          bus.s_tvalid[p]            = 1'b0;
          bus.s_tdata[p*BW +: BW]    = '0;
          bus.s_tlast[p]             = 1'b0;
          bus.s_tkeep[p*KW +: KW]    = '0;
          bus.s_header[p*HS +: HS]   = '0;
        end
      end
      bus.m_tready = (mtr_q.size() > 0) ? mtr_q.pop_front() : 1'b1;
    end
  end

  // ---------------- model ----------------
  int gp = -1, ptr = 0, act = 0, done_pk = 0, cyc = 0;
  logic [HS-1:0] hdr;
  logic [31:0]   cnt;
  int grants[$];
  int grant_cyc[$];
  logic preload = 1'b0;
  int w_nxt;

  function automatic int pick(input logic [NP-1:0] r, input int from);
    for (int k = 0; k < NP; k++) if (r[(from + k) % NP]) return (from + k) % NP;
    return -1;
  endfunction

  always_comb w_nxt = pick(bus.s_tvalid & port_enable, ptr);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      gp <= -1; ptr <= 0; act <= 0; hdr <= '0; cnt <= '0; done_pk <= 0;
      grants.delete(); grant_cyc.delete();
    end else begin
      if (preload) cnt <= '1;
      if (gp < 0) begin
        if (w_nxt >= 0) begin
          gp  <= w_nxt;
          act <= w_nxt;
          hdr <= bus.s_header[w_nxt*HS +: HS];
          grants.push_back(w_nxt);
          grant_cyc.push_back(cyc);
        end
      end else if (bus.s_tvalid[gp] && bus.m_tready && bus.s_tlast[gp]) begin
        gp <= -1; ptr <= (gp + 1) % NP; cnt <= cnt + 1; done_pk <= done_pk + 1;
      end
    end
  end

  function automatic logic exp_valid();
    return (gp >= 0) ? bus.s_tvalid[gp] : 1'b0;
  endfunction

  function automatic logic [NP-1:0] exp_tready();
    return (gp >= 0 && bus.m_tready) ? NP'(1 << gp) : '0;
  endfunction

  // ---------------- compare + scoreboard ----------------
  int sb_beat[NP];
  int xfer[NP];
  int stall = 0;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    for (int p = 0; p < NP; p++) fire[p] <= bus.s_tvalid[p] & bus.s_tready[p];
    checki("m_tvalid", int'(bus.m_tvalid), int'(exp_valid()));
    checki("s_tready", int'(bus.s_tready), int'(exp_tready()));
    checki("busy", int'(busy), int'(gp >= 0));
    checki("active_port", int'(active_port), act);
    checkw("m_header", BW'(bus.m_header), BW'(hdr));
    checki("packet_count", int'(packet_count), int'(cnt));
    if (exp_valid()) begin
      checkw("m_tdata", bus.m_tdata, bus.s_tdata[gp*BW +: BW]);
      checki("m_tlast", int'(bus.m_tlast), int'(bus.s_tlast[gp]));
      checkw("m_tkeep", BW'(bus.m_tkeep), BW'(bus.s_tkeep[gp*KW +: KW]));
    end
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        sb_beat[p] <= 0;
        xfer[p]    <= 0;
      end
      stall <= 0;
    end else begin
      if (gp >= 0 && !bus.m_tready) stall <= stall + 1;
      if (exp_valid() && bus.m_tready) begin
        checki("sb_port", int'(bus.m_tdata[31:24]), gp);
        checki("sb_beat", int'(bus.m_tdata[15:8]), sb_beat[gp]);
        sb_beat[gp] <= bus.m_tlast ? 0 : sb_beat[gp] + 1;
        xfer[gp]    <= xfer[gp] + 1;
      end
    end
  end

  // ---------------- directed tests ----------------
  task automatic push(input int p, input int len, input int id, input logic [HS-1:0] h);
    pkt_t k;
    k.len = len; k.id = id; k.hdr = h;
    pq[p].push_back(k);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #3 reset = 1'b0;
    @(posedge clock); #3 reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_packets(input string nm, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_pk >= n && gp < 0) break;
      @(negedge clock);
    end
    checki(nm, done_pk, n);
  endtask

  initial begin
    reset = 1'b0;
    port_enable = '1;
    repeat (2) @(negedge clock);
    checki("rst busy", int'(busy), 0);
    checki("rst count", int'(packet_count), 0);
    checkw("rst m_header", BW'(bus.m_header), '0);
    checki("rst active", int'(active_port), 0);
    checki("rst m_tvalid", int'(bus.m_tvalid), 0);
    checki("rst s_tready", int'(bus.s_tready), 0);
    reset = 1'b1;
    @(negedge clock);

    // T1: lone port 2, 3 beats
    push(2, 3, 1, {14{8'hA5}});
    @(negedge clock);
    checki("t1 still idle", int'(busy), 0);
    @(negedge clock);
    checki("t1 granted", int'(busy), 1);
    checki("t1 active", int'(active_port), 2);
    checkw("t1 header", BW'(bus.m_header), BW'({14{8'hA5}}));
    wait_packets("t1 done", 1, 50);
    checki("t1 count", int'(packet_count), 1);
    checki("t1 model ptr", ptr, 3);
    checki("t1 rr_ptr", int'(dut.rr_ptr_q), 3);
    checki("t1 beats", xfer[2], 3);
    checkw("t1 header held", BW'(bus.m_header), BW'({14{8'hA5}}));

    // T2: all ports valid, 2-beat packets
    pulse_reset();
    push(0, 2, 1, {7{16'h0001}}); push(0, 2, 2, {7{16'h0002}});
    push(1, 2, 1, {7{16'h0101}}); push(2, 2, 1, {7{16'h0201}}); push(3, 2, 1, {7{16'h0301}});
    wait_packets("t2 done", 5, 200);
    checki("t2 count", int'(packet_count), 5);
    checki("t2 ngrants", grants.size(), 5);
    for (int i = 0; i < 5; i++) checki("t2 order", grants[i], i % 4);
    for (int i = 1; i < 5; i++) checki("t2 spacing", grant_cyc[i] - grant_cyc[i-1], 3);

    // T3: port 1 with m_tready stalls
    pulse_reset();
    push(1, 4, 7, {7{16'h1707}});
    mtr_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    wait_packets("t3 done", 1, 100);
    checki("t3 beats", xfer[1], 4);
    checki("t3 stalls", stall, 2);

    // T4: port mask, port 1 disabled mid-packet
    pulse_reset();
    port_enable = 4'b1011;
    push(0, 2, 1, '0); push(1, 4, 1, '1); push(1, 4, 2, '1);
    push(2, 2, 1, '0); push(3, 2, 1, '0);
    for (int i = 0; i < 50 && gp != 1; i++) @(negedge clock);
    checki("t4 port1 granted", gp, 1);
    port_enable = 4'b1001;
    wait_packets("t4 done", 3, 200);
    repeat (10) @(negedge clock);
    checki("t4 parked", int'(busy), 0);
    checki("t4 ngrants", grants.size(), 3);
    checki("t4 g0", grants[0], 0);
    checki("t4 g1", grants[1], 1);
    checki("t4 g2", grants[2], 3);
    checki("t4 port1 beats", xfer[1], 4);
    checki("t4 port2 beats", xfer[2], 0);
    port_enable = '1;

    // T5: single-beat packet, then reset mid-packet
    pulse_reset();
    push(1, 1, 1, '0);
    wait_packets("t5 single", 1, 50);
    checki("t5 ptr", int'(dut.rr_ptr_q), 2);
    push(2, 4, 1, '0);
    for (int i = 0; i < 50 && xfer[2] < 2; i++) @(negedge clock);
    checki("t5 beats before rst", xfer[2], 2);
    #2 reset = 1'b0;
    #1;
    checki("t5 m_tvalid", int'(bus.m_tvalid), 0);
    checki("t5 s_tready", int'(bus.s_tready), 0);
    checki("t5 busy", int'(busy), 0);
    checki("t5 count", int'(packet_count), 0);
    @(posedge clock); #3 reset = 1'b1;
    @(negedge clock);
    push(3, 1, 2, '0); push(0, 1, 2, '0);
    wait_packets("t5 after", 2, 50);
    checki("t5 first", grants[0], 0);
    checki("t5 second", grants[1], 3);

    // T6: counter wrap via backdoor preload
    pulse_reset();
    @(posedge clock); #2;
    force dut.packet_count_d = 32'hFFFF_FFFF;
    preload = 1'b1;
    @(posedge clock); #2;
    release dut.packet_count_d;
    preload = 1'b0;
    @(negedge clock);
    checki("t6 preload", int'(packet_count), int'(32'hFFFF_FFFF));
    push(3, 1, 3, '0);
    wait_packets("t6 done", 1, 50);
    checki("t6 wrap", int'(packet_count), 0);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
